// File: rtl/text_pkg.sv
// Shared definitions for the text entry/reader blocks: default buffer geometry,
// the NUL terminator code and the streamer state encoding.
package text_pkg;

    localparam int unsigned DEF_NUM_CHARS = 32;
    localparam int unsigned DEF_CHAR_W    = 8;

    localparam logic [7:0] CHAR_NUL = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/text_shift_reg.sv
// Parallel-load, shift-left-by-one-character register with zero fill.
// Exposes the top character it will hold after the coming edge.
module text_shift_reg
    import text_pkg::*;
#(
    parameter int unsigned NUM_CHARS = DEF_NUM_CHARS,
    parameter int unsigned CHAR_W    = DEF_CHAR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic                          shift,
    input  logic [NUM_CHARS*CHAR_W-1:0]   par_in,
    output logic [CHAR_W-1:0]             top_d_c
);

    localparam int unsigned BUF_W = NUM_CHARS * CHAR_W;

    logic [BUF_W-1:0] sr_q;
    logic [BUF_W-1:0] sr_d;

    // Load has priority; shift drops the top character and zero-fills the bottom.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = par_in;
        end else if (shift) begin
            sr_d = {sr_q[BUF_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign top_d_c = sr_d[BUF_W-1 -: CHAR_W];

endmodule

// File: rtl/text_reader.sv
// Streams a packed character buffer one character at a time under a `next` handshake.
// Define TEXT_READER_STOP_AT_NUL_EN to end the string at the first NUL character.
module text_reader
    import text_pkg::*;
#(
    parameter int unsigned NUM_CHARS = DEF_NUM_CHARS,
    parameter int unsigned CHAR_W    = DEF_CHAR_W
) (
    input  logic                                Clk,
    input  logic                                Resetn,
    input  logic                                load,
    input  logic [NUM_CHARS*CHAR_W-1:0]         text_in,
    input  logic                                next,
    output logic [CHAR_W-1:0]                   data_out,
    output logic                                valid,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(NUM_CHARS+1)-1:0]      count
);

    localparam int unsigned     CNT_W    = $clog2(NUM_CHARS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHARS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_CHARS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CHAR_W-1:0]  data_q;
    logic [CHAR_W-1:0]  top_d_c;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sr_load, sr_shift;

    text_shift_reg #(
        .NUM_CHARS (NUM_CHARS),
        .CHAR_W    (CHAR_W)
    ) u_shift (
        .clk     (Clk),
        .rst_n   (Resetn),
        .load    (sr_load),
        .shift   (sr_shift),
        .par_in  (text_in),
        .top_d_c (top_d_c)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sr_load = 1'b1;
                    count_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
`ifdef TEXT_READER_STOP_AT_NUL_EN
                if (data_q == CHAR_W'(CHAR_NUL)) begin
                    state_d = DONE;
                end else
`endif
                if (next) begin
                    sr_shift = 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (count_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
`ifdef TEXT_READER_STOP_AT_NUL_EN
        valid_d = (state_d == SEND) && (top_d_c != CHAR_W'(CHAR_NUL));
`else
        valid_d = (state_d == SEND);
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= top_d_c;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule
